// File: rtl/icache_refill_engine.sv
// Instruction-cache line refill engine: accepts one miss, fetches the line as a burst of
// narrow in-order word reads, and returns the assembled line as a single-cycle pulse.
module icache_refill_engine #(
   parameter int unsigned LINE_BYTES      = 32,
   parameter int unsigned MEM_DATA_BITS   = 32,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       miss_req_valid,
   input  logic [31:0]                miss_req_addr,
   output logic                       miss_req_ready,
   output logic                       miss_resp_valid,
   output logic [LINE_BYTES*8-1:0]    miss_resp_data,
   output logic                       miss_resp_err,
   output logic                       mem_req_valid,
   output logic [31:0]                mem_req_addr,
   input  logic                       mem_req_ready,
   input  logic                       mem_resp_valid,
   input  logic [MEM_DATA_BITS-1:0]   mem_resp_data,
   input  logic                       mem_resp_err,
   output logic                       busy
);

   localparam int unsigned LineBits = LINE_BYTES * 8;
   localparam int unsigned Beats    = LineBits / MEM_DATA_BITS;
   localparam int unsigned MemBytes = MEM_DATA_BITS / 8;
   localparam int unsigned WordSh   = $clog2(MemBytes);
   localparam int unsigned CntW     = $clog2(Beats + 1);
   localparam int unsigned OutW     = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [CntW-1:0] BeatsC  = CntW'(Beats);
   localparam logic [CntW-1:0] LastC   = CntW'(Beats - 1);
   localparam logic [OutW-1:0] MaxOutC = OutW'(MAX_OUTSTANDING);
   localparam logic [31:0]     OffMask = 32'(LINE_BYTES - 1);

   typedef enum logic [1:0] {StIdle, StFill, StResp} state_e;

   state_e                state_q, state_d;
   logic [31:0]           base_q, base_d;
   logic [CntW-1:0]       req_cnt_q, req_cnt_d;
   logic [CntW-1:0]       rsp_cnt_q, rsp_cnt_d;
   logic [OutW-1:0]       out_q, out_d;
   logic                  err_q, err_d;
   logic [LineBits-1:0]   line_q, line_d;
   logic                  req_fire;
   logic                  rsp_take;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         base_q    <= '0;
         req_cnt_q <= '0;
         rsp_cnt_q <= '0;
         out_q     <= '0;
         err_q     <= 1'b0;
         line_q    <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         req_cnt_q <= req_cnt_d;
         rsp_cnt_q <= rsp_cnt_d;
         out_q     <= out_d;
         err_q     <= err_d;
         line_q    <= line_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      base_d          = base_q;
      req_cnt_d       = req_cnt_q;
      rsp_cnt_d       = rsp_cnt_q;
      out_d           = out_q;
      err_d           = err_q;
      line_d          = line_q;
      miss_req_ready  = 1'b0;
      miss_resp_valid = 1'b0;
      mem_req_valid   = 1'b0;
      req_fire        = 1'b0;
      rsp_take        = 1'b0;

      unique case (state_q)
         StIdle: begin
            miss_req_ready = 1'b1;
            if (miss_req_valid) begin
               base_d    = miss_req_addr & ~OffMask;
               req_cnt_d = '0;
               rsp_cnt_d = '0;
               out_d     = '0;
               err_d     = 1'b0;
               state_d   = StFill;
            end
         end
         StFill: begin
            mem_req_valid = (req_cnt_q < BeatsC) && (out_q < MaxOutC);
            req_fire      = mem_req_valid && mem_req_ready;
            rsp_take      = mem_resp_valid;
            if (req_fire) begin
               req_cnt_d = req_cnt_q + CntW'(1);
            end
            if (rsp_take) begin
               for (int b = 0; b < int'(Beats); b++) begin
                  if (rsp_cnt_q == CntW'(b)) begin
                     line_d[b*MEM_DATA_BITS +: MEM_DATA_BITS] = mem_resp_data;
                  end
               end
               rsp_cnt_d = rsp_cnt_q + CntW'(1);
               err_d     = err_q | mem_resp_err;
               // Errors never abort: every beat is collected so outstanding drains to zero.
               if (rsp_cnt_q == LastC) begin
                  state_d = StResp;
               end
            end
            if (req_fire && !rsp_take) begin
               out_d = out_q + OutW'(1);
            end else if (!req_fire && rsp_take) begin
               out_d = out_q - OutW'(1);
            end
         end
         StResp: begin
            miss_resp_valid = 1'b1;
            state_d         = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign mem_req_addr   = base_q + (32'(req_cnt_q) << WordSh);
   assign miss_resp_data = line_q;
   assign miss_resp_err  = (state_q == StResp) && err_q;
   assign busy           = (state_q != StIdle);

endmodule
